// File: rtl/wb_ram_burst.sv
// wb_ram_burst: Wishbone B4 single-port RAM slave with registered-feedback incrementing bursts.
// Define WB_RAM_BURST_ERR_EN to add err_o, which rejects reserved cycle-type codes.
module wb_ram_burst #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o
`ifdef WB_RAM_BURST_ERR_EN
    ,
    output logic                    err_o
`endif
);

    localparam int LSB   = $clog2(SELECT_WIDTH);
    localparam int AW    = ADDR_WIDTH - LSB;
    localparam int DEPTH = 1 << AW;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [AW-1:0]           cur_adr_r;
    logic [AW-1:0]           cur_adr_nxt_s;
    logic [AW-1:0]           word_adr_s;
    logic [AW-1:0]           wr_adr_s;
    logic [AW-1:0]           rd_adr_s;
    logic                    wr_en_s;
    logic                    rd_en_s;
    logic                    ack_nxt_s;
    logic                    req_s;
    logic                    err_cti_s;

    // Contents start at zero and are never touched by rst_n.
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH] = '{default: '0};

    // Burst address step: wrapN keeps the bits above the N-word boundary fixed.
    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
        logic [AW-1:0] mask;
        logic [AW-1:0] inc;
        inc = a + {{(AW-1){1'b0}}, 1'b1};
        case (bte)
            2'b01:   mask = {{(AW-2){1'b0}}, 2'b11};
            2'b10:   mask = {{(AW-3){1'b0}}, 3'b111};
            2'b11:   mask = {{(AW-4){1'b0}}, 4'b1111};
            default: mask = {AW{1'b1}};
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    assign word_adr_s = adr_i[ADDR_WIDTH-1:LSB];

    generate
        if (LSB > 0) begin : g_adr_lsb
            logic adr_lsb_unused_s;
            assign adr_lsb_unused_s = ^adr_i[LSB-1:0];
        end
    endgenerate

`ifdef WB_RAM_BURST_ERR_EN
    logic err_nxt_s;
    assign req_s     = cyc_i & stb_i & ~ack_o & ~err_o;
    assign err_cti_s = (cti_i == 3'b001) || ((cti_i >= 3'b011) && (cti_i <= 3'b110));
`else
    assign req_s     = cyc_i & stb_i & ~ack_o;
    assign err_cti_s = 1'b0;
`endif

    // Next-state, memory strobes and output staging for the IDLE/BURST controller.
    always_comb begin
        state_nxt_s   = state_r;
        cur_adr_nxt_s = cur_adr_r;
        ack_nxt_s     = 1'b0;
        wr_en_s       = 1'b0;
        wr_adr_s      = cur_adr_r;
        rd_en_s       = 1'b0;
        rd_adr_s      = cur_adr_r;
`ifdef WB_RAM_BURST_ERR_EN
        err_nxt_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (err_cti_s) begin
`ifdef WB_RAM_BURST_ERR_EN
                        err_nxt_s = 1'b1;
`endif
                        state_nxt_s = IDLE;
                    end else begin
                        wr_en_s       = we_i;
                        wr_adr_s      = word_adr_s;
                        rd_en_s       = 1'b1;
                        rd_adr_s      = word_adr_s;
                        ack_nxt_s     = 1'b1;
                        cur_adr_nxt_s = word_adr_s;
                        if (cti_i == CTI_INCR) begin
                            state_nxt_s = BURST;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (!cyc_i) begin
                    state_nxt_s = IDLE;
                end else if (stb_i && ack_o) begin
                    wr_en_s = we_i;
                    if ((cti_i == CTI_END) || (cti_i == CTI_CLASSIC)) begin
                        state_nxt_s = IDLE;
                    end else begin
                        cur_adr_nxt_s = next_adr(cur_adr_r, bte_i);
                        rd_en_s       = 1'b1;
                        rd_adr_s      = next_adr(cur_adr_r, bte_i);
                        ack_nxt_s     = 1'b1;
                    end
                end else if (stb_i) begin
                    // Strobe returns after a wait state: re-present the pending beat.
                    rd_en_s   = 1'b1;
                    rd_adr_s  = cur_adr_r;
                    ack_nxt_s = 1'b1;
                end else begin
                    ack_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Byte-lane writes; suppressed while rst_n is low so a reset never corrupts memory.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (wr_en_s && rst_n && sel_i[i]) begin
                mem_r[wr_adr_s][i*8 +: 8] <= dat_i[i*8 +: 8];
            end
        end
    end

    // Controller state and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cur_adr_r <= '0;
            ack_o     <= 1'b0;
            dat_o     <= '0;
        end else begin
            state_r   <= state_nxt_s;
            cur_adr_r <= cur_adr_nxt_s;
            ack_o     <= ack_nxt_s;
            if (rd_en_s) begin
                dat_o <= mem_r[rd_adr_s];
            end
        end
    end

`ifdef WB_RAM_BURST_ERR_EN
    // One-cycle error pulse for rejected cycle types.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else begin
            err_o <= err_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_wb_ram_burst.sv
// Self-checking bench for wb_ram_burst: table of classic accesses, directed burst corner
// cases, and randomized classic/burst traffic against a word-array reference model.
module tb_wb_ram_burst;

    localparam int DEPTH = 16384;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic        ack_o;
`ifdef WB_RAM_BURST_ERR_EN
    logic        err_o;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] bd [16];
    logic [3:0]  bs [16];
    vec_t        tbl [10];

    wb_ram_burst dut (
        .clk   (clk),
        .rst_n (rst_n),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .sel_i (sel_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .cti_i (cti_i),
        .bte_i (bte_i),
        .ack_o (ack_o)
`ifdef WB_RAM_BURST_ERR_EN
        ,
        .err_o (err_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mem_m[w][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Word address of beat j of a burst starting at word s.
    function automatic int baddr(input int s, input logic [1:0] bte, input int j);
        int n;
        if (bte == 2'b00) return (s + j) % DEPTH;
        n = 2 << bte;
        return (s / n) * n + ((s % n) + j) % n;
    endfunction

    task automatic classic(input logic we, input logic [15:0] adr, input logic [31:0] d,
                           input logic [3:0] sel, input logic [2:0] cti,
                           input logic [31:0] exp_dat, input string name);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = d; sel_i = sel;
        cti_i = cti; bte_i = 2'b00;
        step();
        chk({name, " ack"}, 32'(ack_o), 32'd1);
        chk({name, " dat"}, dat_o, exp_dat);
        if (we) model_write(int'(adr >> 2), d, sel);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        step();
        chk({name, " ack drop"}, 32'(ack_o), 32'd0);
    endtask

    // Burst of n beats using bd/bs; when wait_j >= 1 the master stalls 2 cycles on beat wait_j.
    task automatic do_burst(input logic we, input int start, input logic [1:0] bte,
                            input int n, input int wait_j, input string name);
        int          j;
        logic        waited;
        logic [31:0] exp;
        exp = mem_m[baddr(start, bte, 0)];
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = 16'(start * 4);
        cti_i = 3'b010; bte_i = bte; dat_i = bd[0]; sel_i = bs[0];
        step();
        j = 0;
        waited = 1'b0;
        while (j < n) begin
            chk({name, " beat ack"}, 32'(ack_o), 32'd1);
            chk({name, " beat dat"}, dat_o, exp);
            cti_i = (j == n - 1) ? 3'b111 : 3'b010;
            dat_i = bd[j];
            sel_i = bs[j];
            if (!waited && j == wait_j) begin
                waited = 1'b1;
                stb_i = 1'b0;
                step();
                chk({name, " wait ack1"}, 32'(ack_o), 32'd0);
                step();
                chk({name, " wait ack2"}, 32'(ack_o), 32'd0);
                stb_i = 1'b1;
                step();
            end else begin
                if (we) model_write(baddr(start, bte, j), bd[j], bs[j]);
                step();
                j++;
                if (j < n) exp = mem_m[baddr(start, bte, j)];
            end
        end
        chk({name, " end ack"}, 32'(ack_o), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
        step();
    endtask

    initial begin : main
        int          kind;
        int          w;
        int          n;
        int          nmax;
        int          start;
        int          wj;
        logic        wr;
        logic [1:0]  bt;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  ct;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        rst_n = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 16'h0;
        dat_i = 32'h0; sel_i = 4'h0; cti_i = 3'b000; bte_i = 2'b00;
        step();
        step();
        chk("reset ack", 32'(ack_o), 32'd0);
        chk("reset dat", dat_o, 32'h0);
`ifdef WB_RAM_BURST_ERR_EN
        chk("reset err", 32'(err_o), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h00000000};
        tbl[1] = '{1'b1, 16'h0010, 32'h000000AA, 4'h1, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 16'h0010, 32'h00000000, 4'hF, 32'hDEADBEAA};
        tbl[3] = '{1'b1, 16'h0012, 32'h12345678, 4'h6, 32'hDEADBEAA};
        tbl[4] = '{1'b0, 16'h0011, 32'hFFFFFFFF, 4'hF, 32'hDE3456AA};
        tbl[5] = '{1'b1, 16'hFFFC, 32'hCAFEF00D, 4'hF, 32'h00000000};
        tbl[6] = '{1'b1, 16'hFFFC, 32'h11223344, 4'h0, 32'hCAFEF00D};
        tbl[7] = '{1'b0, 16'hFFFE, 32'h00000000, 4'hF, 32'hCAFEF00D};
        tbl[8] = '{1'b1, 16'h0000, 32'hA5A5A5A5, 4'h8, 32'h00000000};
        tbl[9] = '{1'b0, 16'h0000, 32'h00000000, 4'hF, 32'hA5000000};
        for (int i = 0; i < 10; i++) begin
            classic(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, 3'b000, tbl[i].exp,
                    $sformatf("table[%0d]", i));
        end

        // Preload words 4..7 = 1..4, then a linear read burst.
        for (int i = 0; i < 4; i++) begin
            classic(1'b1, 16'((4 + i) * 4), 32'(i + 1), 4'hF, 3'b000, mem_m[4 + i], "preload");
        end
        for (int i = 0; i < 4; i++) begin bd[i] = 32'h0; bs[i] = 4'hF; end
        do_burst(1'b0, 4, 2'b00, 4, -1, "linear");

        // Wrap4 write burst from word 2 lands on words 2,3,0,1.
        bd[0] = 32'h0000000A; bd[1] = 32'h0000000B; bd[2] = 32'h0000000C; bd[3] = 32'h0000000D;
        do_burst(1'b1, 2, 2'b01, 4, -1, "wrap4 wr");
        classic(1'b0, 16'h0008, 32'h0, 4'hF, 3'b000, 32'h0000000A, "wrap4 w2");
        classic(1'b0, 16'h000C, 32'h0, 4'hF, 3'b000, 32'h0000000B, "wrap4 w3");
        classic(1'b0, 16'h0000, 32'h0, 4'hF, 3'b000, 32'h0000000C, "wrap4 w0");
        classic(1'b0, 16'h0004, 32'h0, 4'hF, 3'b000, 32'h0000000D, "wrap4 w1");

        // Linear read with a 2-cycle master stall on the third beat.
        do_burst(1'b0, 4, 2'b00, 4, 2, "wait");

        // Held request: acceptance gated by ack_o gives one ack every two cycles.
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'h0010; cti_i = 3'b000; sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b ack", 32'(ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) chk("b2b dat", dat_o, 32'h00000001);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        step();

        classic(1'b0, 16'h0014, 32'h0, 4'hF, 3'b111, 32'h00000002, "cti111 classic");
`ifdef WB_RAM_BURST_ERR_EN
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0010; dat_i = 32'hFFFFFFFF;
        sel_i = 4'hF; cti_i = 3'b011;
        step();
        chk("err pulse", 32'(err_o), 32'd1);
        chk("err no ack", 32'(ack_o), 32'd0);
        chk("err dat hold", dat_o, 32'h00000002);
        step();
        chk("err pulse end", 32'(err_o), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        step();
        step();
        classic(1'b0, 16'h0010, 32'h0, 4'hF, 3'b000, 32'h00000001, "err mem kept");
`else
        classic(1'b0, 16'h0010, 32'h0, 4'hF, 3'b011, 32'h00000001, "cti011 classic");
`endif

        // Reset in the middle of a write burst.
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'(20 * 4); cti_i = 3'b010;
        bte_i = 2'b00; dat_i = 32'h11112222; sel_i = 4'hF;
        step();
        chk("rst burst ack", 32'(ack_o), 32'd1);
        model_write(20, 32'h11112222, 4'hF);
        step();
        chk("rst burst beat1", 32'(ack_o), 32'd1);
        dat_i = 32'h33334444;
        rst_n = 1'b0;
        #1;
        chk("rst async ack", 32'(ack_o), 32'd0);
        chk("rst async dat", dat_o, 32'h0);
        step();
        step();
        chk("rst held ack", 32'(ack_o), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
        rst_n = 1'b1;
        step();
        classic(1'b0, 16'(21 * 4), 32'h0, 4'hF, 3'b000, mem_m[21], "rst mem21");
        classic(1'b0, 16'(20 * 4), 32'h0, 4'hF, 3'b000, 32'h11112222, "rst mem20");

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 2);
            wr   = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                w  = $urandom_range(0, 63);
                d  = $urandom;
                s  = 4'($urandom_range(0, 15));
                ct = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
                classic(wr, 16'(w * 4 + $urandom_range(0, 3)), d, s, ct, mem_m[w], "rnd classic");
            end else begin
                bt    = 2'($urandom_range(0, 3));
                nmax  = (bt == 2'b00) ? 6 : (2 << bt);
                if (nmax > 6) nmax = 6;
                n     = $urandom_range(2, nmax);
                start = (bt == 2'b00 && $urandom_range(0, 3) == 0) ? DEPTH - 3
                                                                   : $urandom_range(0, 63);
                for (int j = 0; j < n; j++) begin
                    bd[j] = $urandom;
                    bs[j] = 4'($urandom_range(0, 15));
                end
                wj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
                do_burst(wr, start, bt, n, wj, "rnd burst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
